// File: rtl/vedic_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_arith_pkg
//  Description : Shared declarations for the vedic arithmetic unit. Holds the
//                divider state encoding and the power-of-two width check that
//                both the multiplier and the divider use at elaboration.
//  Contents    : div_state_t (IDLE/RUN/DONE), is_pow2()
//  Revision    : 1.0 - initial release
// ============================================================================
package vedic_arith_pkg;

  // Explicit encodings so the state register has a fixed, documented layout.
  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_RUN  = 2'd1;
  localparam logic [1:0] DIV_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = DIV_ST_IDLE,
    RUN  = DIV_ST_RUN,
    DONE = DIV_ST_DONE
  } div_state_t;

  // True when value is a positive power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage : vedic_arith_pkg
`default_nettype wire

// File: rtl/cla_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nbit
//  Description : WIDTH-bit carry-lookahead adder. Carries are produced by a
//                parallel-prefix (Kogge-Stone style) combination of group
//                generate/propagate terms, so the carry depth is log2(WIDTH).
//  Ports       : a, b   - addends (WIDTH)
//                cin    - carry in
//                sum    - a + b + cin, low WIDTH bits
//                cout   - carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_nbit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] w_p_bit;   // per-bit propagate (a ^ b)
  logic [WIDTH-1:0] w_grp_g;   // group generate; after the last level bit i is the carry out of bit i
  logic [WIDTH-1:0] w_grp_p;   // group propagate

  // Carry-in is folded into bit 0's generate, so every group that reaches
  // bit 0 already accounts for it and no separate carry-in path is needed.
  always_comb begin
    w_p_bit    = a ^ b;
    w_grp_g    = a & b;
    w_grp_g[0] = (a[0] & b[0]) | (w_p_bit[0] & cin);
    w_grp_p    = w_p_bit;
    for (int lv = 0; lv < LEVELS; lv++) begin
      // Merge each group with the one 2^lv positions below. Low bits whose
      // span already reaches bit 0 are final: they merge with zero generate
      // and keep their propagate (ones shifted in).
      w_grp_g = w_grp_g | (w_grp_p & (w_grp_g << (1 << lv)));
      w_grp_p = w_grp_p & ((w_grp_p << (1 << lv)) | ~({WIDTH{1'b1}} << (1 << lv)));
    end
  end

  assign sum  = w_p_bit ^ {w_grp_g[WIDTH-2:0], cin};
  assign cout = w_grp_g[WIDTH-1];

endmodule : cla_nbit
`default_nettype wire

// File: rtl/vedic_nbit_div.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_nbit_div
//  Description : Sequential unsigned restoring radix-2 divider. Divides a
//                2*WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit
//                per clock, returning WIDTH-bit quotient and remainder. It is
//                the inverse of vedic_nbit_mul: (a*b)/b returns a, rem 0.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                in_valid/in_ready - input handshake (ready only in IDLE)
//                dividend, divisor - operands, sampled on input handshake
//                out_valid/out_ready - output handshake (valid only in DONE)
//                quotient, remainder - registered results
//                div_by_zero       - divisor was zero
//                overflow          - quotient would not fit in WIDTH bits
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_nbit_div
  import vedic_arith_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int                CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time width check
  // --------------------------------------------------------------------------
  generate
    if (!is_pow2(WIDTH) || (WIDTH < 2)) begin : g_bad_width
      $fatal(1, "vedic_nbit_div: WIDTH must be a power of two and at least 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  div_state_t         r_state;
  logic [WIDTH-1:0]   r_div;        // latched divisor D
  logic [WIDTH-1:0]   r_rem;        // partial remainder R
  logic [WIDTH-1:0]   r_q;          // quotient shifter Q (starts as dividend low half)
  logic [CNT_W-1:0]   r_cnt;        // iterations completed
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;
  logic               r_ovf;

  // --------------------------------------------------------------------------
  // One restoring iteration
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   w_shift;      // low WIDTH bits of {R, Q[W-1]}
  logic [WIDTH-1:0]   w_diff;
  logic               w_cout;
  logic               w_sub_ok;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_next;

  assign w_shift = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};

  // w_shift - D computed as w_shift + ~D + 1.
  cla_nbit #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .a    (w_shift),
    .b    (~r_div),
    .cin  (1'b1),
    .sum  (w_diff),
    .cout (w_cout)
  );

  // The shifted remainder is WIDTH+1 bits wide. If its top bit (R[W-1]) is
  // set it certainly exceeds D; otherwise the carry out says w_shift >= D.
  // In the first case the WIDTH-bit difference is still exact because the
  // true result is below D.
  assign w_sub_ok   = r_rem[WIDTH-1] | w_cout;
  assign w_rem_next = w_sub_ok ? w_diff : w_shift;
  assign w_q_next   = {r_q[WIDTH-2:0], w_sub_ok};

  // --------------------------------------------------------------------------
  // Control and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_div <= divisor;
            r_rem <= dividend[2*WIDTH-1:WIDTH];
            r_q   <= dividend[WIDTH-1:0];
            r_cnt <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            if (divisor == '0) begin
              r_dbz       <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= dividend[WIDTH-1:0];
              r_state     <= DONE;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              // High half already >= D: quotient needs more than WIDTH bits.
              r_ovf       <= 1'b1;
              r_quotient  <= '0;
              r_remainder <= '0;
              r_state     <= DONE;
            end else begin
              r_state <= RUN;
            end
          end
        end

        RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // The last iteration writes its results straight to the outputs.
          if (r_cnt == LAST_ITER) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (handshake flags decode from state only)
  // --------------------------------------------------------------------------
  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule : vedic_nbit_div
`default_nettype wire

// File: tb/tb_vedic_nbit_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vedic_nbit_div
//  Description : Scoreboard bench for vedic_nbit_div at WIDTH 8, 16 and 64.
//                Stimulus pushes the expected result into a per-instance
//                queue; a monitor pops and compares on each output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_nbit_div;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;   // edges from handshake (inclusive) until out_valid
  } exp_t;

  logic clk;
  logic rst_n;

  logic iv   [3];
  logic ordy [3];
  logic ir   [3];
  logic ov   [3];
  logic dz   [3];
  logic ofl  [3];

  logic [15:0]  n8;   logic [7:0]  d8;  logic [7:0]  q8;  logic [7:0]  r8;
  logic [31:0]  n16;  logic [15:0] d16; logic [15:0] q16; logic [15:0] r16;
  logic [127:0] n64;  logic [63:0] d64; logic [63:0] q64; logic [63:0] r64;

  bit   manual_rdy [3];
  logic manual_val [3];
  bit   rand_stall;

  int   checks;
  int   errors;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  bit          hold [3];
  logic [63:0] hq   [3];
  logic [63:0] hr   [3];

  // --------------------------------------------------------------------------
  // DUTs
  // --------------------------------------------------------------------------
  vedic_nbit_div #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .dividend(n8), .divisor(d8), .out_valid(ov[0]), .out_ready(ordy[0]),
    .quotient(q8), .remainder(r8), .div_by_zero(dz[0]), .overflow(ofl[0])
  );

  vedic_nbit_div #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .dividend(n16), .divisor(d16), .out_valid(ov[1]), .out_ready(ordy[1]),
    .quotient(q16), .remainder(r16), .div_by_zero(dz[1]), .overflow(ofl[1])
  );

  vedic_nbit_div #(.WIDTH(64)) u_div64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .dividend(n64), .divisor(d64), .out_valid(ov[2]), .out_ready(ordy[2]),
    .quotient(q64), .remainder(r64), .div_by_zero(dz[2]), .overflow(ofl[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic int width_of(input int k);
    case (k)
      0:       return 8;
      1:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic logic [63:0] get_q(input int k);
    case (k)
      0:       return 64'(q8);
      1:       return 64'(q16);
      default: return q64;
    endcase
  endfunction

  function automatic logic [63:0] get_r(input int k);
    case (k)
      0:       return 64'(r8);
      1:       return 64'(r16);
      default: return r64;
    endcase
  endfunction

  // Reference: plain integer division with the error rules applied first.
  function automatic exp_t model(input int w, input logic [127:0] n, input logic [63:0] d);
    exp_t e;
    logic [127:0] mask;
    logic [127:0] hi;
    logic [127:0] lo;
    mask  = (128'd1 << w) - 128'd1;
    hi    = (n >> w) & mask;
    lo    = n & mask;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (d == 64'd0) begin
      e.dbz = 1'b1; e.q = 64'(mask); e.r = 64'(lo); e.lat = 1;
    end else if (hi >= 128'(d)) begin
      e.ovf = 1'b1; e.q = 64'd0; e.r = 64'd0; e.lat = 1;
    end else begin
      e.q = 64'(n / 128'(d)); e.r = 64'(n % 128'(d)); e.lat = w + 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_pop(input int k, output exp_t e);
    case (k)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic wait_idle(input int k);
    int guard;
    guard = 0;
    while (ir[k] !== 1'b1) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 1000) begin
        fail_note($sformatf("w%0d_in_ready_timeout", width_of(k)));
        return;
      end
    end
  endtask

  // Issue one operation, push its expectation, and measure latency.
  task automatic issue(input int k, input logic [127:0] n, input logic [63:0] d, input exp_t e);
    int lat;
    wait_idle(k);
    case (k)
      0:       begin n8  = n[15:0]; d8  = d[7:0];  end
      1:       begin n16 = n[31:0]; d16 = d[15:0]; end
      default: begin n64 = n;       d64 = d;       end
    endcase
    sb_push(k, e);
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 1;
    while ((ov[k] !== 1'b1) && (lat < 300)) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("w%0d_latency", width_of(k)), 64'(lat), 64'(e.lat));
  endtask

  // out_ready driver: manual override, random stalls, or held high.
  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (manual_rdy[k])  ordy[k] = manual_val[k];
        else if (rand_stall) ordy[k] = ($urandom_range(0, 3) != 0);
        else                 ordy[k] = 1'b1;
      end
    end
  endtask

  // Monitor: compares on every output handshake, and checks that a stalled
  // result holds steady while in_ready stays low.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_n !== 1'b1) begin
          hold[k] = 1'b0;
        end else if (ov[k] === 1'b1) begin
          if (hold[k]) begin
            chk($sformatf("w%0d_stall_quotient", width_of(k)), get_q(k), hq[k]);
            chk($sformatf("w%0d_stall_remainder", width_of(k)), get_r(k), hr[k]);
            chk($sformatf("w%0d_in_ready_in_done", width_of(k)), 64'(ir[k]), 64'd0);
          end
          if (ordy[k] === 1'b1) begin
            hold[k] = 1'b0;
            if (sb_size(k) == 0) begin
              fail_note($sformatf("w%0d_unexpected_output", width_of(k)));
            end else begin
              sb_pop(k, e);
              chk($sformatf("w%0d_quotient", width_of(k)), get_q(k), e.q);
              chk($sformatf("w%0d_remainder", width_of(k)), get_r(k), e.r);
              chk($sformatf("w%0d_div_by_zero", width_of(k)), 64'(dz[k]), 64'(e.dbz));
              chk($sformatf("w%0d_overflow", width_of(k)), 64'(ofl[k]), 64'(e.ovf));
            end
          end else begin
            hold[k] = 1'b1;
            hq[k]   = get_q(k);
            hr[k]   = get_r(k);
          end
        end else begin
          hold[k] = 1'b0;
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  logic [15:0] dir_n [5];
  logic [7:0]  dir_d [5];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rand_stall = 1'b0;
    n8 = '0; d8 = '0; n16 = '0; d16 = '0; n64 = '0; d64 = '0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; hold[k] = 1'b0;
      manual_rdy[k] = 1'b0; manual_val[k] = 1'b0;
      hq[k] = '0; hr[k] = '0;
    end
    dir_n[0] = 16'h3039; dir_d[0] = 8'h64;
    dir_n[1] = 16'hFE01; dir_d[1] = 8'hFF;
    dir_n[2] = 16'h00FE; dir_d[2] = 8'hFF;
    dir_n[3] = 16'h1234; dir_d[3] = 8'h00;
    dir_n[4] = 16'h6400; dir_d[4] = 8'h64;

    fork
      ready_driver();
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w%0d_rst_in_ready", width_of(k)),  64'(ir[k]),  64'd1);
      chk($sformatf("w%0d_rst_out_valid", width_of(k)), 64'(ov[k]),  64'd0);
      chk($sformatf("w%0d_rst_quotient", width_of(k)),  get_q(k),    64'd0);
      chk($sformatf("w%0d_rst_remainder", width_of(k)), get_r(k),    64'd0);
      chk($sformatf("w%0d_rst_dbz", width_of(k)),       64'(dz[k]),  64'd0);
      chk($sformatf("w%0d_rst_ovf", width_of(k)),       64'(ofl[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=8 cases: normal, max quotient, zero quotient, /0, overflow
    for (int i = 0; i < 5; i++) begin
      issue(0, 128'(dir_n[i]), 64'(dir_d[i]), model(8, 128'(dir_n[i]), 64'(dir_d[i])));
    end

    // Backpressure: result held in DONE until out_ready
    wait_idle(0);
    manual_val[0] = 1'b0;
    manual_rdy[0] = 1'b1;
    issue(0, 128'(16'h3039), 64'(8'h64), model(8, 128'(16'h3039), 64'(8'h64)));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(ov[0]), 64'd1);
      chk("bp_in_ready",  64'(ir[0]), 64'd0);
    end
    manual_val[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  64'(ir[0]), 64'd1);
    chk("bp_release_out_valid", 64'(ov[0]), 64'd0);
    manual_rdy[0] = 1'b0;

    // Reset on the 4th RUN cycle aborts the operation
    wait_idle(0);
    n8 = 16'h3039; d8 = 8'h64; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready",  64'(ir[0]),  64'd1);
    chk("abort_out_valid", 64'(ov[0]),  64'd0);
    chk("abort_quotient",  get_q(0),    64'd0);
    chk("abort_remainder", get_r(0),    64'd0);
    chk("abort_flags",     64'({dz[0], ofl[0]}), 64'd0);
    issue(0, 128'(16'h3039), 64'(8'h64), model(8, 128'(16'h3039), 64'(8'h64)));

    // Randomized traffic with out_ready stalls on all three widths
    rand_stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] rn;
          logic [7:0]  rd;
          int          sel;
          sel = int'($urandom_range(0, 7));
          rd  = (sel == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          rn  = 16'($urandom_range(0, 65535));
          if ((sel >= 2) && (rd != 8'h00)) rn[15:8] = 8'($urandom_range(0, int'(rd) - 1));
          issue(0, 128'(rn), 64'(rd), model(8, 128'(rn), 64'(rd)));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [15:0] a1;
          logic [15:0] b1;
          exp_t        e1;
          a1 = 16'($urandom_range(1, 65535));
          b1 = 16'($urandom_range(1, 65535));
          e1.q = 64'(a1); e1.r = 64'd0; e1.dbz = 1'b0; e1.ovf = 1'b0; e1.lat = 17;
          issue(1, 128'(32'(a1) * 32'(b1)), 64'(b1), e1);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [63:0] a2;
          logic [63:0] b2;
          exp_t        e2;
          a2 = {$urandom, $urandom};
          b2 = {$urandom, $urandom};
          if (a2 == 64'd0) a2 = 64'd1;
          if (b2 == 64'd0) b2 = 64'd1;
          e2.q = a2; e2.r = 64'd0; e2.dbz = 1'b0; e2.ovf = 1'b0; e2.lat = 65;
          issue(2, 128'(a2) * 128'(b2), b2, e2);
        end
      end
    join

    rand_stall = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w%0d_scoreboard_drained", width_of(k)), 64'(sb_size(k)), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_vedic_nbit_div
`default_nettype wire
